// File: rtl/mlp_seq_ctrl.sv
// Bus-master sequencer for the mlp accelerator: streams both weight layers from a
// synchronous ROM, then runs one input vector per handshake and returns output 0.
module mlp_seq_ctrl #(
    parameter int N_INPUTS  = 2,
    parameter int N_HIDDEN  = 4,
    parameter int N_OUTPUT  = 1,
    parameter int IN_WIDTH  = 16,
    parameter int WGT_WIDTH = 16,
    parameter int OUT_WIDTH = 16,
    parameter int ROM_AW    = 8,
    parameter int TIMEOUT   = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         reload_w,
    output logic                         rom_rd_en,
    output logic [ROM_AW-1:0]            rom_addr,
    input  logic [WGT_WIDTH-1:0]         rom_rdata,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N_INPUTS*IN_WIDTH-1:0] in_data,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [OUT_WIDTH-1:0]         res_data,
    output logic                         mlp_write_en,
    output logic [1:0]                   mlp_addr,
    output logic [31:0]                  mlp_writedata,
    input  logic [31:0]                  mlp_readdata,
    output logic                         busy,
    output logic                         weights_loaded,
    output logic                         err
);

    localparam int NW1 = N_HIDDEN * (N_INPUTS + 1);
    localparam int NW2 = N_OUTPUT * (N_HIDDEN + 1);
    localparam int CW  = 16;
    localparam int PW  = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] NW1_C    = CW'(NW1);
    localparam logic [CW-1:0] NW2_C    = CW'(NW2);
    localparam logic [CW-1:0] NIN_LAST = CW'(N_INPUTS - 1);
    localparam logic [PW-1:0] TO_C     = PW'(TIMEOUT);

    localparam logic [1:0] A_CTRL = 2'd0;
    localparam logic [1:0] A_IN   = 2'd1;
    localparam logic [1:0] A_WGT  = 2'd2;
    localparam logic [1:0] A_OUT  = 2'd3;

    // Handshakes: a transfer happens on a rising clk edge where valid && ready;
    // in_ready depends only on state, and res_valid/res_data hold until res_ready.
    typedef enum logic [3:0] {
        S_IDLE, S_SEL1, S_W1, S_SEL2, S_W2, S_READY,
        S_INW, S_RUN, S_POLL, S_ACK, S_CAP, S_RES
    } state_t;

    state_t                        state_q, state_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic [PW-1:0]                 poll_q, poll_d;
    logic [N_INPUTS*IN_WIDTH-1:0]  vec_q, vec_d;
    logic [OUT_WIDTH-1:0]          res_q, res_d;
    logic                          wl_q, wl_d;
    logic                          err_q, err_d;
    logic                          unused_rd;

    assign unused_rd = ^mlp_readdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            poll_q  <= '0;
            vec_q   <= '0;
            res_q   <= '0;
            wl_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            poll_q  <= poll_d;
            vec_q   <= vec_d;
            res_q   <= res_d;
            wl_q    <= wl_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        poll_d        = poll_q;
        vec_d         = vec_q;
        res_d         = res_q;
        wl_d          = wl_q;
        err_d         = err_q;
        rom_rd_en     = 1'b0;
        rom_addr      = '0;
        in_ready      = 1'b0;
        res_valid     = 1'b0;
        mlp_write_en  = 1'b0;
        mlp_addr      = A_CTRL;
        mlp_writedata = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d   = 1'b0;
                    state_d = S_SEL1;
                end
            end
            S_SEL1: begin
                mlp_write_en = 1'b1;
                cnt_d        = '0;
                state_d      = S_W1;
            end
            // Read of word k overlaps the FIFO write of word k-1 (ROM latency 1).
            S_W1: begin
                if (cnt_q < NW1_C) begin
                    rom_rd_en = 1'b1;
                    rom_addr  = ROM_AW'(cnt_q);
                end
                if (cnt_q != '0) begin
                    mlp_write_en  = 1'b1;
                    mlp_addr      = A_WGT;
                    mlp_writedata = 32'($signed(rom_rdata));
                end
                if (cnt_q == NW1_C) state_d = S_SEL2;
                else                cnt_d   = cnt_q + CW'(1);
            end
            S_SEL2: begin
                mlp_write_en  = 1'b1;
                mlp_writedata = 32'h8;
                cnt_d         = '0;
                state_d       = S_W2;
            end
            S_W2: begin
                if (cnt_q < NW2_C) begin
                    rom_rd_en = 1'b1;
                    rom_addr  = ROM_AW'(NW1_C + cnt_q);
                end
                if (cnt_q != '0) begin
                    mlp_write_en  = 1'b1;
                    mlp_addr      = A_WGT;
                    mlp_writedata = 32'($signed(rom_rdata));
                end
                if (cnt_q == NW2_C) begin
                    wl_d    = 1'b1;
                    state_d = S_READY;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_READY: begin
                in_ready = 1'b1;
                if (reload_w) begin
                    wl_d    = 1'b0;
                    state_d = S_SEL1;
                end else if (in_valid) begin
                    vec_d   = in_data;
                    cnt_d   = '0;
                    state_d = S_INW;
                end
            end
            // Element 0 sits in the low bits; shift so the next element moves down.
            S_INW: begin
                mlp_write_en  = 1'b1;
                mlp_addr      = A_IN;
                mlp_writedata = 32'($signed(vec_q[IN_WIDTH-1:0]));
                vec_d         = vec_q >> IN_WIDTH;
                if (cnt_q == NIN_LAST) state_d = S_RUN;
                else                   cnt_d   = cnt_q + CW'(1);
            end
            S_RUN: begin
                mlp_write_en  = 1'b1;
                mlp_writedata = 32'h1;
                poll_d        = '0;
                state_d       = S_POLL;
            end
            // First poll cycle sees status registered before RUN landed, so skip it.
            S_POLL: begin
                poll_d = poll_q + PW'(1);
                if (poll_q != '0 && mlp_readdata[1]) begin
                    state_d = S_ACK;
                end else if (poll_d == TO_C) begin
                    err_d   = 1'b1;
                    state_d = S_READY;
                end
            end
            S_ACK: begin
                mlp_write_en = 1'b1;
                mlp_addr     = A_OUT;
                cnt_d        = '0;
                state_d      = S_CAP;
            end
            S_CAP: begin
                mlp_addr = A_OUT;
                if (cnt_q != '0) begin
                    res_d   = mlp_readdata[OUT_WIDTH-1:0];
                    state_d = S_RES;
                end else begin
                    cnt_d = CW'(1);
                end
            end
            S_RES: begin
                res_valid = 1'b1;
                if (res_ready) state_d = S_READY;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign res_data       = res_q;
    assign busy           = (state_q != S_IDLE) && (state_q != S_READY);
    assign weights_loaded = wl_q;
    assign err            = err_q;

endmodule

// File: tb/tb_mlp_seq_ctrl.sv
// Self-checking bench for mlp_seq_ctrl: ROM and mlp slave models, an expected
// bus-write / ROM-read / result scoreboard, and directed timing checks.
module tb_mlp_seq_ctrl;

    localparam int TIMEOUT    = 32;
    localparam int DONE_DELAY = 20;
    localparam int NW1        = 12;
    localparam int NW2        = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        reload_w = 1'b0;
    logic        rom_rd_en;
    logic [7:0]  rom_addr;
    logic [15:0] rom_rdata = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic        mlp_write_en;
    logic [1:0]  mlp_addr;
    logic [31:0] mlp_writedata;
    logic [31:0] mlp_readdata = '0;
    logic        busy;
    logic        weights_loaded;
    logic        err;

    mlp_seq_ctrl #(
        .N_INPUTS(2), .N_HIDDEN(4), .N_OUTPUT(1), .IN_WIDTH(16), .WGT_WIDTH(16),
        .OUT_WIDTH(16), .ROM_AW(8), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .reload_w(reload_w),
        .rom_rd_en(rom_rd_en), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .mlp_write_en(mlp_write_en), .mlp_addr(mlp_addr), .mlp_writedata(mlp_writedata),
        .mlp_readdata(mlp_readdata), .busy(busy), .weights_loaded(weights_loaded), .err(err)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- ROM and slave models ----------------
    logic [15:0] rom [256];
    logic        done_en = 1'b1;
    logic [15:0] out_val = '0;
    logic        done_flag = 1'b0;
    int          done_timer = 0;

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = '0;
        for (int i = 0; i < NW1 + NW2; i++)
            rom[i] = (i % 3 == 0) ? 16'(-(i + 1) * 300) : 16'(i * 257 + 3);
    end

    always @(posedge clk) begin
        if (rom_rd_en) rom_rdata <= rom[rom_addr];
    end

    always @(posedge clk) begin
        if (mlp_write_en && mlp_addr == 2'd0 && mlp_writedata[0]) begin
            done_flag  <= 1'b0;
            done_timer <= done_en ? DONE_DELAY : 0;
        end else if (done_timer != 0) begin
            done_timer <= done_timer - 1;
            if (done_timer == 1) done_flag <= 1'b1;
        end
        case (mlp_addr)
            2'd0:    mlp_readdata <= {30'b0, done_flag, 1'b0};
            2'd3:    mlp_readdata <= {16'hDEAD, out_val};
            default: mlp_readdata <= '0;
        endcase
    end

    // ---------------- scoreboard ----------------
    logic [33:0] exp_w_q[$];
    logic [7:0]  exp_rom_q[$];
    logic [15:0] exp_r_q[$];
    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic miss(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event did not occur / unexpected (t=%0t)", name, $time);
    endtask

    function automatic logic [31:0] sx(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [33:0] wr(input logic [1:0] a, input logic [31:0] d);
        return {a, d};
    endfunction

    task automatic push_weights();
        exp_w_q.push_back(wr(2'd0, 32'h0));
        for (int k = 0; k < NW1; k++) exp_w_q.push_back(wr(2'd2, sx(rom[k])));
        exp_w_q.push_back(wr(2'd0, 32'h8));
        for (int k = NW1; k < NW1 + NW2; k++) exp_w_q.push_back(wr(2'd2, sx(rom[k])));
        for (int k = 0; k < NW1 + NW2; k++) exp_rom_q.push_back(8'(k));
    endtask

    logic [33:0] e_w;
    logic [7:0]  e_rom;
    logic [15:0] e_r;

    always @(negedge clk) begin
        if (mlp_write_en) begin
            if (exp_w_q.size() == 0) begin
                miss("bus_write_unexpected");
                $display("  write addr %0d data %08h", mlp_addr, mlp_writedata);
            end else begin
                e_w = exp_w_q.pop_front();
                chk("bus_write", {30'b0, mlp_addr, mlp_writedata}, {30'b0, e_w});
            end
        end else begin
            chk("idle_writedata", 64'(mlp_writedata), 64'h0);
        end
        if (rom_rd_en) begin
            if (exp_rom_q.size() == 0) miss("rom_read_unexpected");
            else begin
                e_rom = exp_rom_q.pop_front();
                chk("rom_addr", 64'(rom_addr), 64'(e_rom));
            end
        end
        chk("ready_busy_excl", 64'(in_ready & busy), 64'h0);
        if (res_valid && res_ready) begin
            if (exp_r_q.size() == 0) miss("result_unexpected");
            else begin
                e_r = exp_r_q.pop_front();
                chk("res_data", 64'(res_data), 64'(e_r));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Full weight load from start (or reload_w+in_valid together): 21 busy cycles.
    task automatic do_load(input bit use_reload);
        bit bad = 1'b0;
        push_weights();
        @(posedge clk); #1;
        if (use_reload) begin
            reload_w = 1'b1; in_valid = 1'b1; in_data = 32'h0005_0004;
        end else start = 1'b1;
        @(posedge clk); #1;
        reload_w = 1'b0; in_valid = 1'b0; start = 1'b0;
        for (int i = 1; i <= 21; i++) begin
            @(negedge clk);
            if (!busy || weights_loaded) bad = 1'b1;
        end
        chk("load_busy_no_wl", 64'(bad), 64'h0);
        @(negedge clk);
        chk("load_done_wl", 64'(weights_loaded), 64'h1);
        chk("load_done_ready", 64'(in_ready), 64'h1);
        chk("load_done_busy", 64'(busy), 64'h0);
    endtask

    task automatic send_vec(input logic [15:0] a, input logic [15:0] b, input bit den,
                            input logic [15:0] outv, input int hold, input bit tie);
        int k;
        bit ok;
        done_en = den;
        out_val = outv;
        exp_w_q.push_back(wr(2'd1, sx(a)));
        exp_w_q.push_back(wr(2'd1, sx(b)));
        exp_w_q.push_back(wr(2'd0, 32'h1));
        if (den) begin
            exp_w_q.push_back(wr(2'd3, 32'h0));
            exp_r_q.push_back(outv);
        end
        in_data = {b, a};
        in_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            if (in_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin miss("in_handshake"); in_valid = 1'b0; return; end
        @(posedge clk); #1 in_valid = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (mlp_write_en && mlp_addr == 2'd0 && mlp_writedata == 32'h1) begin ok = 1'b1; break; end
        end
        if (!ok) begin miss("run_write"); return; end
        if (den) begin
            k = 0;
            for (int t = 1; t <= 60; t++) begin
                @(negedge clk);
                if (res_valid) begin k = t; break; end
            end
            chk("done_latency", 64'(k), 64'd26);
            if (k == 0) return;
            chk("res_data_first", 64'(res_data), 64'(outv));
            if (tie) begin
                @(negedge clk);
                chk("in_ready_after_res", 64'(in_ready), 64'h1);
            end else begin
                for (int h = 0; h < hold; h++) begin
                    @(negedge clk);
                    chk("res_valid_held", 64'(res_valid), 64'h1);
                    chk("res_data_held", 64'(res_data), 64'(outv));
                end
                @(posedge clk); #1 res_ready = 1'b1;
                @(posedge clk); #1 res_ready = 1'b0;
                @(negedge clk);
                chk("in_ready_after_res", 64'(in_ready), 64'h1);
                chk("res_valid_dropped", 64'(res_valid), 64'h0);
            end
        end else begin
            repeat (TIMEOUT) @(negedge clk);
            chk("poll_last_busy", 64'(busy), 64'h1);
            chk("poll_last_err", 64'(err), 64'h0);
            @(negedge clk);
            chk("timeout_err", 64'(err), 64'h1);
            chk("timeout_ready", 64'(in_ready), 64'h1);
            chk("timeout_wl", 64'(weights_loaded), 64'h1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'h0);
        chk({tag, "_busy"}, 64'(busy), 64'h0);
        chk({tag, "_wl"}, 64'(weights_loaded), 64'h0);
        chk({tag, "_err"}, 64'(err), 64'h0);
        chk({tag, "_res_valid"}, 64'(res_valid), 64'h0);
        chk({tag, "_res_data"}, 64'(res_data), 64'h0);
        chk({tag, "_write_en"}, 64'(mlp_write_en), 64'h0);
        chk({tag, "_addr"}, 64'(mlp_addr), 64'h0);
        chk({tag, "_rom_rd_en"}, 64'(rom_rd_en), 64'h0);
        chk({tag, "_rom_addr"}, 64'(rom_addr), 64'h0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int nw;
        bit hit;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        do_load(1'b0);
        send_vec(16'd7, 16'hFFFD, 1'b1, 16'h0123, 3, 1'b0);
        send_vec(16'h8000, 16'h7FFF, 1'b1, 16'hFEDC, 0, 1'b0);

        send_vec(16'd100, 16'hFF9C, 1'b0, 16'h0000, 0, 1'b0);
        pulse_start();
        @(negedge clk);
        chk("start_ignored_ready", 64'(in_ready), 64'h1);
        chk("start_ignored_err", 64'(err), 64'h1);

        do_load(1'b1);
        chk("err_sticky", 64'(err), 64'h1);

        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("reset_ready");

        push_weights();
        pulse_start();
        nw = 0;
        hit = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (mlp_write_en && mlp_addr == 2'd2) nw++;
            if (nw == 6) begin rst_n = 1'b0; hit = 1'b1; break; end
        end
        if (!hit) miss("sixth_w1_write");
        @(posedge clk); #1;
        exp_w_q.delete();
        exp_rom_q.delete();
        exp_r_q.delete();
        @(negedge clk);
        check_all_zero("reset_mid_w1");
        rst_n = 1'b1;
        do_load(1'b0);

        res_ready = 1'b1;
        send_vec(16'd1, 16'd2, 1'b1, 16'h0042, 0, 1'b1);
        send_vec(16'hFFFF, 16'd300, 1'b1, 16'h8001, 0, 1'b1);
        res_ready = 1'b0;

        repeat (4) @(negedge clk);
        chk("writes_drained", 64'(exp_w_q.size()), 64'h0);
        chk("rom_reads_drained", 64'(exp_rom_q.size()), 64'h0);
        chk("results_drained", 64'(exp_r_q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
